// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push-side round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Modulo increment that also handles n that is not a power of two.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side and FIFO-side push handshake bundle for fifo_push_arbiter.
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int BW = DATA_WIDTH + 1;

    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_last_i;
    logic [NUM_REQ*BW-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_grant_o;
    logic                  fifo_push_valid_o;
    logic [BW-1:0]         fifo_push_data_o;
    logic                  fifo_push_grant_i;

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, fifo_push_grant_i,
        output req_grant_o, fifo_push_valid_o, fifo_push_data_o
    );

    modport master (
        output req_valid_i, req_last_i, req_data_i, fifo_push_grant_i,
        input  req_grant_o, fifo_push_valid_o, fifo_push_data_o
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or above i_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);
    int unsigned w_cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
            if (i_valid[w_cand]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ bursting requesters.
//   state  | meaning
//   IDLE   | round-robin pick from rr_ptr each cycle; single-beat bursts stay here
//   LOCKED | owner holds the port until its last beat or MAX_BURST beats
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 8,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_push_arbiter_if.slave bus,
    output logic [IDX_W-1:0]   owner_o,
    output logic               locked_o,
    output logic               trunc_o
);
    localparam int BW    = DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic             r_trunc, w_trunc_nxt;

    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_sel;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_accept;
    logic [IDX_W-1:0] w_sel_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid (bus.req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_sel       = (r_state == LOCKED) ? r_owner : w_pick_idx;
    assign w_sel_valid = bus.req_valid_i[w_sel];
    assign w_sel_last  = bus.req_last_i[w_sel];
    assign w_accept    = rst_n && w_sel_valid && bus.fifo_push_grant_i;
    assign w_sel_inc   = IDX_W'(rr_next(int'(w_sel), NUM_REQ));

    // Outputs are gated by rst_n so they are quiet for the whole reset window.
    always_comb begin
        bus.req_grant_o        = '0;
        bus.req_grant_o[w_sel] = w_accept;
        bus.fifo_push_valid_o  = rst_n && w_sel_valid;
        bus.fifo_push_data_o   = rst_n ? bus.req_data_i[int'(w_sel)*BW +: BW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_trunc    <= w_trunc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        w_trunc_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                // Tracking the pick keeps owner_o steady when nobody is valid.
                if (w_found) w_owner_nxt = w_pick_idx;
                if (w_accept) begin
                    if (w_sel_last || MAX_BURST == 1) begin
                        w_rr_ptr_nxt = w_sel_inc;
                    end else begin
                        w_state_nxt    = LOCKED;
                        w_beat_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    if (w_sel_last || r_beat_cnt == CNT_LAST) begin
                        w_state_nxt    = IDLE;
                        w_rr_ptr_nxt   = w_sel_inc;
                        w_beat_cnt_nxt = '0;
                        w_trunc_nxt    = !w_sel_last;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign owner_o  = (r_state == IDLE && w_found) ? w_pick_idx : r_owner;
    assign locked_o = (r_state == LOCKED);
    assign trunc_o  = r_trunc;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: random and directed stimulus against a behavioural model.
module tb_fifo_push_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int BW = DW + 1;
    localparam int IW = $clog2(NR);

    typedef struct {
        logic          rst;
        logic          pv;
        logic [NR-1:0] gnt;
        logic [BW-1:0] data;
        int            owner;
        logic          lck;
        logic          trc;
    } exp_t;

    typedef struct {
        int            idx;
        logic [BW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] owner;
    logic          locked;
    logic          trunc;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    // Reference model state: which requester holds the port (-1 = none),
    // beats taken in that ownership, next search start, pending trunc pulse.
    int   m_locked = -1;
    int   m_cnt = 0;
    int   m_ptr = 0;
    int   m_last_owner = 0;
    logic m_trunc_pend = 1'b0;

    fifo_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_push_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .owner_o  (owner),
        .locked_o (locked),
        .trunc_o  (trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle status from exp_q, accepted beats from beat_q.
    initial begin
        exp_t          e;
        beat_t         b;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("push_valid", 64'(bus.fifo_push_valid_o), 64'(e.pv));
                chk("grant", 64'(bus.req_grant_o), 64'(e.gnt));
                chk("locked", 64'(locked), 64'(e.lck));
                chk("trunc", 64'(trunc), 64'(e.trc));
                if (e.rst || e.pv) chk("push_data", 64'(bus.fifo_push_data_o), 64'(e.data));
                if (!e.rst) chk("owner", 64'(owner), 64'(e.owner));
            end
            if (bus.fifo_push_valid_o && bus.fifo_push_grant_i) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: grant %0h with no expected beat at %0t",
                             bus.req_grant_o, $time);
                end else begin
                    b = beat_q.pop_front();
                    oh = '0;
                    oh[b.idx] = 1'b1;
                    chk("beat_grant", 64'(bus.req_grant_o), 64'(oh));
                    chk("beat_data", 64'(bus.fifo_push_data_o), 64'(b.data));
                end
            end
        end
    end

    // One clock of stimulus; computes expected outputs from the model and advances it.
    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l,
                         input logic fg, input logic rst_now);
        exp_t          e;
        beat_t         b;
        logic [NR*BW-1:0] d;
        int            sel;
        logic          found;
        logic          acc;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) d[k*BW +: BW] = BW'($urandom);
        rst_n = !rst_now;
        bus.req_valid_i = v;
        bus.req_last_i = l;
        bus.req_data_i = d;
        bus.fifo_push_grant_i = fg;
        e = '{rst: rst_now, pv: 1'b0, gnt: '0, data: '0, owner: 0, lck: 1'b0, trc: 1'b0};
        if (rst_now) begin
            m_locked = -1;
            m_cnt = 0;
            m_ptr = 0;
            m_last_owner = 0;
            m_trunc_pend = 1'b0;
            exp_q.push_back(e);
            return;
        end
        e.trc = m_trunc_pend;
        m_trunc_pend = 1'b0;
        e.lck = (m_locked >= 0);
        sel = 0;
        found = 1'b0;
        if (m_locked >= 0) begin
            sel = m_locked;
            found = 1'b1;
        end else begin
            for (int off = 0; off < NR; off++) begin
                if (!found && v[(m_ptr + off) % NR]) begin
                    sel = (m_ptr + off) % NR;
                    found = 1'b1;
                end
            end
        end
        e.pv = found && v[sel];
        if (m_locked >= 0) e.owner = m_locked;
        else if (found) e.owner = sel;
        else e.owner = m_last_owner;
        if (m_locked < 0 && found) m_last_owner = sel;
        e.data = d[sel*BW +: BW];
        acc = e.pv && fg;
        if (acc) begin
            e.gnt[sel] = 1'b1;
            b.idx = sel;
            b.data = d[sel*BW +: BW];
            beat_q.push_back(b);
            if (m_locked < 0) begin
                if (l[sel] || MB == 1) begin
                    m_ptr = (sel + 1) % NR;
                end else begin
                    m_locked = sel;
                    m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (l[sel] || m_cnt == MB) begin
                    m_trunc_pend = !l[sel];
                    m_ptr = (sel + 1) % NR;
                    m_locked = -1;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic run_random(input int n, input int vp, input int lp,
                              input int gp, input int rp);
        logic [NR-1:0] v;
        logic [NR-1:0] l;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NR; k++) begin
                v[k] = ($urandom_range(99) < vp);
                l[k] = ($urandom_range(99) < lp);
            end
            drive(v, l, $urandom_range(99) < gp, $urandom_range(999) < rp);
        end
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_last_i = '0;
        bus.req_data_i = '0;
        bus.fifo_push_grant_i = 1'b0;
        // reset with everything requesting
        repeat (3) drive('1, '1, 1'b1, 1'b1);
        // single-beat round robin 0,1,2,3,0
        repeat (5) drive('1, '1, 1'b1, 1'b0);
        // requester 2 three-beat burst with requester 0 competing
        drive(4'b0101, 4'b0000, 1'b1, 1'b0);
        drive(4'b0101, 4'b0000, 1'b1, 1'b0);
        drive(4'b0101, 4'b0100, 1'b1, 1'b0);
        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        // truncation of requester 1, requester 3 then takes over
        repeat (6) drive(4'b1010, 4'b0000, 1'b1, 1'b0);
        repeat (4) drive(4'b0010, 4'b0000, 1'b1, 1'b0);
        // backpressure and owner valid gap inside a burst
        drive(4'b0001, 4'b0000, 1'b1, 1'b0);
        repeat (5) drive(4'b1111, 4'b0000, 1'b0, 1'b0);
        repeat (2) drive(4'b1110, 4'b0000, 1'b1, 1'b0);
        drive(4'b1111, 4'b0001, 1'b1, 1'b0);
        // mid-burst reset on beat 2 of 5
        drive(4'b0100, 4'b0000, 1'b1, 1'b0);
        drive(4'b0100, 4'b0000, 1'b1, 1'b1);
        drive('1, '1, 1'b1, 1'b0);
        // randomized mixes
        run_random(400, 60, 30, 75, 0);
        run_random(200, 80, 0, 90, 0);
        run_random(300, 50, 40, 60, 15);
        run_random(100, 100, 100, 100, 0);
        drive('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the push side of one FIFO among NUM_REQ requesters. Requesters send multi-beat bursts. Once a requester wins, it keeps the FIFO until its last beat is accepted or MAX_BURST beats have been accepted. The block sits directly in front of the FIFO push port and uses the same valid/grant handshake on both sides.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, default 32: data beats are DATA_WIDTH+1 bits wide, matching the FIFO push port ([DATA_WIDTH:0]).
- MAX_BURST, default 8: maximum number of beats accepted per ownership; must be ≥ 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_last_i  in  NUM_REQ  per-requester last-beat-of-burst flag; qualified by req_valid_i.
- req_data_i  in  NUM_REQ*(DATA_WIDTH+1)  flattened beats; requester k occupies bits [k*(DATA_WIDTH+1) +: DATA_WIDTH+1].
- req_grant_o  out  NUM_REQ  per-requester grant; at most one bit high (one-hot or zero).
- fifo_push_valid_o  out  1  to FIFO push_valid_i.
- fifo_push_data_o  out  DATA_WIDTH+1  to FIFO push_data_i.
- fifo_push_grant_i  in  1  from FIFO push_grant_o.
- owner_o  out  $clog2(NUM_REQ)  currently selected requester.
- locked_o  out  1  high while in LOCKED.
- trunc_o  out  1  one-cycle pulse when a burst is cut off at MAX_BURST.

## Operation
- Beat acceptance: a beat is accepted when fifo_push_valid_o && fifo_push_grant_i.
- Selection is combinational:
  - fifo_push_valid_o = req_valid_i[sel].
  - fifo_push_data_o = slice sel of req_data_i.
  - req_grant_o[sel] = fifo_push_grant_i && req_valid_i[sel]; all other grant bits are 0.
- State machine, with states in the shared package:
  - IDLE:
    - sel is the first requester with valid high, searching upward from rr_ptr with wrap-around.
    - If no requester is valid, fifo_push_valid_o = 0 and owner_o holds its last value.
    - When a beat is accepted:
      - If last is set or MAX_BURST == 1, go to END: rr_ptr = sel+1 mod NUM_REQ and stay in IDLE.
      - Otherwise, latch owner = sel, set beat_cnt = 1 and go to LOCKED.
  - LOCKED:
    - sel = owner, whatever the other valids are.
    - If the owner drops valid, the FIFO sees no valid and the lock is held; other requesters are never granted mid-burst.
    - Each accepted beat increments beat_cnt.
    - An accepted beat with last set goes to IDLE with rr_ptr = owner+1 mod NUM_REQ.
    - An accepted beat without last, when beat_cnt == MAX_BURST-1, takes the same transition and also asserts trunc_o for the following cycle.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
  - rr_ptr wraps explicitly at NUM_REQ-1, because NUM_REQ need not be a power of two.
- req_last_i is ignored on beats that are not accepted.
- Reset, asynchronous:
  - State goes to IDLE; rr_ptr, owner and beat_cnt go to 0; trunc_o goes to 0.
  - While rst_n is low, req_grant_o, fifo_push_valid_o and locked_o are forced to 0, and fifo_push_data_o is 0.
  - Reset in the middle of a burst discards the lock with no trunc_o pulse.

## Timing
- Grant path has zero latency: fifo_push_grant_i to req_grant_o is purely combinational, with no register.
- A requester can be accepted in the same cycle it raises valid when the block is in IDLE and the requester wins.
- Back-to-back operation:
  - A LOCKED owner can push one beat every cycle.
  - A new winner can push in the cycle immediately after the previous owner's final beat; no dead cycle is inserted.
- locked_o is a registered state bit.
- owner_o is combinational sel in IDLE and the registered owner in LOCKED.
- trunc_o is registered and lasts exactly one cycle.
- When the FIFO is full and pop_grant_i = 0, fifo_push_grant_i = 0: nothing is granted and the state holds.

## Structure
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}.
  - Function rr_next(ptr, n) for modulo increment.
- Sub-module rr_pick: purely combinational. It takes valid[NUM_REQ-1:0] and ptr and returns a found flag and an index. It is instantiated once for IDLE selection.
- The top level holds the state register, rr_ptr, owner, beat_cnt, the trunc_o register and the data mux.

## Test plan
- **Reset:** hold rst_n = 0 with all valids high → all grants 0, fifo_push_valid_o = 0, locked_o = 0.
- **Round-robin:** release reset; requesters 0–3 all valid with last = 1 every beat and fifo_push_grant_i = 1 → grants rotate 0,1,2,3,0, one per cycle.
- **Burst lock:** requester 2 sends a 3-beat burst (last on beat 3) while requester 0 is also valid → grants go to 2 for three cycles, then to 3 if valid, otherwise to 0.
- **Truncation:** MAX_BURST = 4; requester 1 sends 6 beats with no last → 4 grants to 1, trunc_o pulses for one cycle, then another requester is granted, and requester 1 later resumes.
- **Backpressure and valid gap:**
  - fifo_push_grant_i = 0 for 5 cycles during a LOCKED burst → no grants, beat_cnt unchanged.
  - Owner drops valid for 2 cycles → no other requester is granted.
- **Mid-burst reset:** assert rst_n low during beat 2 of 5 → locked_o = 0 immediately; after release, arbitration starts from requester 0.
